// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   fetch_state_e  : fetch control states
//   fetch_entry_t  : buffered fetch entry {pc, inst, err}
//   NopInst        : instruction word presented with a misaligned-fetch fault
//   CntW           : width of the small credit/occupancy counters
package fetch_unit_pkg;

    localparam logic        Enable  = 1'b1;
    localparam logic        Disable = 1'b0;
    localparam logic [31:0] NopInst = 32'h0000_0013;

    // Wide enough to hold outst + occ without overflow for MAX_OUTST <= 2.
    localparam int unsigned CntW = 3;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StErrEmit = 2'd1,
        StHalt    = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO of fetch entries with flush.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : drop all entries (wins over push/pop)
//   push_i     : write entry_i (ignored when full unless popping this cycle)
//   pop_i      : retire head (ignored when empty)
//   entry_o    : head entry (registered storage, no bypass from entry_i)
//   full_o     : two entries held
//   empty_o    : no entries held
module fetch_fifo
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    output fetch_entry_t entry_o,
    output logic         full_o,
    output logic         empty_o
);

    fetch_entry_t mem_q [2];
    logic [1:0]   cnt_q, cnt_d;
    logic         wr_q, rd_q;
    logic         push_ok, pop_ok;

    always_comb begin
        full_o  = (cnt_q == 2'd2);
        empty_o = (cnt_q == 2'd0);
        pop_ok  = pop_i & ~empty_o;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok = push_i & (~full_o | pop_i);
        entry_o = mem_q[rd_q];
        if (flush_i) begin
            cnt_d = 2'd0;
        end else begin
            cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            cnt_q    <= 2'd0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (flush_i) begin
                wr_q <= 1'b0;
                rd_q <= 1'b0;
            end else begin
                if (push_ok) begin
                    mem_q[wr_q] <= entry_i;
                    wr_q        <= ~wr_q;
                end
                if (pop_ok) begin
                    rd_q <= ~rd_q;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order word fetches,
// buffers responses with their PCs and presents them to decode.
//   clk, rst_n               : clock, asynchronous active-low reset
//   redirect_valid/_pc       : execute-stage redirect (level) and target
//   imem_req_valid/_ready    : fetch request handshake
//   imem_req_addr            : byte PC of the request
//   imem_rsp_valid/_data     : in-order response, no backpressure
//   if_valid/_ready          : decode handshake
//   if_pc, if_inst, if_err   : presented entry (if_err = misaligned-fetch fault)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_err
);

    fetch_state_e    state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [CntW-1:0] outst_q, outst_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic [CntW-1:0] occ_d, fifo_cnt;
    logic            req_valid_q, req_valid_d;

    // PCs of requests whose responses will be kept, oldest at pcq_rd_q.
    logic [31:0]     pcq_q [2];
    logic            pcq_rd_q, pcq_wr_q;

    logic            req_hs, rsp_keep, rsp_drop;
    logic            err_push, push, pop;
    logic            fifo_full, fifo_empty;
    fetch_entry_t    push_entry, head;

    always_comb begin
        req_hs   = req_valid_q & imem_req_ready;
        rsp_keep = imem_rsp_valid & (drop_q == '0);
        rsp_drop = imem_rsp_valid & (drop_q != '0);
        pop      = ~fifo_empty & if_ready & ~redirect_valid;
        err_push = (state_q == StErrEmit) & fifo_empty & ~redirect_valid;
        push     = (rsp_keep & ~redirect_valid) | err_push;

        if (err_push) begin
            push_entry.pc   = pc_q;
            push_entry.inst = NopInst;
            push_entry.err  = 1'b1;
        end else begin
            push_entry.pc   = pcq_q[pcq_rd_q];
            push_entry.inst = imem_rsp_data;
            push_entry.err  = 1'b0;
        end

        fifo_cnt = fifo_full ? CntW'(2) : (fifo_empty ? CntW'(0) : CntW'(1));
        outst_d  = outst_q + CntW'(req_hs) - CntW'(imem_rsp_valid);

        pc_d    = pc_q;
        state_d = state_q;
        drop_d  = drop_q;
        occ_d   = fifo_cnt + CntW'(push) - CntW'(pop);
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            drop_d  = outst_d;
            occ_d   = '0;
            pc_d    = redirect_pc;
            state_d = (redirect_pc[1:0] == 2'b00) ? StRun : StErrEmit;
        end else begin
            if (rsp_drop) begin
                drop_d = drop_q - CntW'(1);
            end
            if (req_hs) begin
                pc_d = pc_q + 32'd4;
            end
            if (err_push) begin
                state_d = StHalt;
            end
        end

        // Registered so the request never depends combinationally on redirect/if_ready.
        req_valid_d = (state_d == StRun) && ((outst_d + occ_d) < CntW'(MAX_OUTST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            outst_q     <= '0;
            drop_q      <= '0;
            req_valid_q <= 1'b0;
            pcq_q[0]    <= '0;
            pcq_q[1]    <= '0;
            pcq_rd_q    <= 1'b0;
            pcq_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            req_valid_q <= req_valid_d;
            if (redirect_valid) begin
                pcq_rd_q <= 1'b0;
                pcq_wr_q <= 1'b0;
            end else begin
                if (req_hs) begin
                    pcq_q[pcq_wr_q] <= pc_q;
                    pcq_wr_q        <= ~pcq_wr_q;
                end
                if (rsp_keep) begin
                    pcq_rd_q <= ~pcq_rd_q;
                end
            end
        end
    end

    fetch_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .entry_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign if_valid       = ~fifo_empty;
    assign if_pc          = head.pc;
    assign if_inst        = head.inst;
    assign if_err         = head.err;

endmodule
